// File: rtl/univ_shift_reg.sv
// Universal shift register: hold/shift/rotate/ASR/load/clear, single step or N-step burst.
// Latency: one op per clock; bursts take N clocks with busy/done; no backpressure, RUN ignores inputs.
module univ_shift_reg #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    localparam int                CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [2:0]       i_mode,
    input  logic             i_sd_lsb,
    input  logic             i_sd_msb,
    input  logic [WIDTH-1:0] i_pd,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_amt,
    output logic [WIDTH-1:0] o_q,
    output logic             o_sout,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_ROL  = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ASR  = 3'b101;
    localparam logic [2:0] MODE_LOAD = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    localparam logic [CNT_W-1:0] MAX_AMT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic             done_q, done_d;
    logic [2:0]       mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0]       step_mode;
    logic [WIDTH-1:0] step_q;
    logic             step_sout;
    logic [CNT_W-1:0] amt_sat;

    assign amt_sat = (i_amt > MAX_AMT) ? MAX_AMT : i_amt;

    // A burst replays the latched op; a single step uses the live mode.
    assign step_mode = (state_q == RUN) ? mode_q : i_mode;

    always_comb begin
        step_q    = q_q;
        step_sout = sout_q;
        case (step_mode)
            MODE_SHL: begin
                step_q    = {q_q[WIDTH-2:0], i_sd_lsb};
                step_sout = q_q[WIDTH-1];
            end
            MODE_SHR: begin
                step_q    = {i_sd_msb, q_q[WIDTH-1:1]};
                step_sout = q_q[0];
            end
            MODE_ROL: begin
                step_q    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                step_sout = q_q[WIDTH-1];
            end
            MODE_ROR: begin
                step_q    = {q_q[0], q_q[WIDTH-1:1]};
                step_sout = q_q[0];
            end
            MODE_ASR: begin
                step_q    = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                step_sout = q_q[0];
            end
            MODE_LOAD: step_q = i_pd;
            MODE_CLR:  step_q = '0;
            default:   step_q = q_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        sout_d  = sout_q;
        done_d  = 1'b0;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (amt_sat == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        mode_d  = i_mode;
                        cnt_d   = amt_sat;
                    end
                end else if (i_en) begin
                    q_d    = step_q;
                    sout_d = step_sout;
                end
            end
            RUN: begin
                q_d    = step_q;
                sout_d = step_sout;
                cnt_d  = cnt_q - ONE;
                if (cnt_q == ONE) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            q_q     <= RESET_VAL;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
            mode_q  <= 3'b000;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_q    = q_q;
    assign o_sout = sout_q;
    assign o_busy = (state_q == RUN);
    assign o_done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed and random checks of univ_shift_reg (WIDTH=8) against an arithmetic reference model.
module tb_univ_shift_reg;

    localparam int W = 8;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_en = 1'b0;
    logic [2:0] i_mode = 3'b000;
    logic       i_sd_lsb = 1'b0;
    logic       i_sd_msb = 1'b0;
    logic [7:0] i_pd = 8'h00;
    logic       i_start = 1'b0;
    logic [3:0] i_amt = 4'd0;
    logic [7:0] o_q;
    logic       o_sout;
    logic       o_busy;
    logic       o_done;

    int vectors = 0;
    int miscompares = 0;

    int unsigned m_q;
    int unsigned m_sout;
    int unsigned m_done;
    int          m_left;
    logic [2:0]  m_mode;

    univ_shift_reg #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_mode(i_mode),
        .i_sd_lsb(i_sd_lsb), .i_sd_msb(i_sd_msb), .i_pd(i_pd),
        .i_start(i_start), .i_amt(i_amt),
        .o_q(o_q), .o_sout(o_sout), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    // One operation on the model register, written as plain arithmetic on an integer.
    function automatic void model_op(input logic [2:0] md);
        int unsigned top;
        int unsigned low;
        int unsigned half;
        top  = (m_q >> (W - 1)) & 1;
        low  = m_q % 2;
        half = m_q / 2;
        case (md)
            3'd1: begin m_q = (m_q * 2 + i_sd_lsb) % 256; m_sout = top; end
            3'd2: begin m_q = half + i_sd_msb * 128;        m_sout = low; end
            3'd3: begin m_q = (m_q * 2) % 256 + top;        m_sout = top; end
            3'd4: begin m_q = half + low * 128;             m_sout = low; end
            3'd5: begin m_q = half + top * 128;             m_sout = low; end
            3'd6: m_q = i_pd;
            3'd7: m_q = 0;
            default: ;
        endcase
    endfunction

    function automatic void model_clock();
        int n;
        if (m_left > 0) begin
            model_op(m_mode);
            m_left = m_left - 1;
            m_done = (m_left == 0) ? 1 : 0;
        end else begin
            m_done = 0;
            if (i_start) begin
                n = (int'(i_amt) > W) ? W : int'(i_amt);
                if (n == 0) m_done = 1;
                else begin
                    m_mode = i_mode;
                    m_left = n;
                end
            end else if (i_en) begin
                model_op(i_mode);
            end
        end
    endfunction

    function automatic void model_reset();
        m_q = 0; m_sout = 0; m_done = 0; m_left = 0; m_mode = 3'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".q"},    {24'd0, o_q},    m_q);
        chk({tag, ".sout"}, {31'd0, o_sout}, m_sout);
        chk({tag, ".busy"}, {31'd0, o_busy}, (m_left > 0) ? 32'd1 : 32'd0);
        chk({tag, ".done"}, {31'd0, o_done}, m_done);
    endtask

    task automatic drv(input logic en, input logic st, input logic [2:0] md,
                       input logic [3:0] amt, input logic lsb, input logic msb, input logic [7:0] pd);
        i_en = en; i_start = st; i_mode = md; i_amt = amt;
        i_sd_lsb = lsb; i_sd_msb = msb; i_pd = pd;
    endtask

    task automatic tick(input string tag);
        @(posedge i_clk);
        model_clock();
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic load(input logic [7:0] v);
        drv(1'b1, 1'b0, 3'd6, 4'd0, 1'b0, 1'b0, v);
        tick("load");
    endtask

    initial begin
        model_reset();
        #1;
        check_all("reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Basic shifts
        load(8'hA5);
        drv(1'b1, 1'b0, 3'd1, 4'd0, 1'b1, 1'b0, 8'h00); tick("shl");
        chk("shl_const", {24'd0, o_q}, 32'h4B);
        drv(1'b1, 1'b0, 3'd2, 4'd0, 1'b0, 1'b0, 8'h00); tick("shr");
        chk("shr_const", {24'd0, o_q}, 32'h25);
        chk("shr_sout_const", {31'd0, o_sout}, 32'd1);

        load(8'h96);
        drv(1'b1, 1'b0, 3'd5, 4'd0, 1'b0, 1'b0, 8'h00); tick("asr");
        chk("asr_const", {24'd0, o_q}, 32'hCB);
        drv(1'b1, 1'b0, 3'd4, 4'd0, 1'b0, 1'b0, 8'h00); tick("ror");
        chk("ror_const", {24'd0, o_q}, 32'hE5);
        idle(); tick("hold");

        // ROL burst of 3
        load(8'h81);
        drv(1'b0, 1'b1, 3'd3, 4'd3, 1'b0, 1'b0, 8'h00); tick("rol_start");
        idle();
        for (int k = 0; k < 3; k++) tick("rol_step");
        chk("rol_const", {24'd0, o_q}, 32'h0C);
        chk("rol_done_const", {31'd0, o_done}, 32'd1);
        tick("rol_after");

        // Zero-length burst, then saturating burst
        drv(1'b0, 1'b1, 3'd1, 4'd0, 1'b1, 1'b1, 8'h00); tick("amt0");
        chk("amt0_done_const", {31'd0, o_done}, 32'd1);
        idle(); tick("amt0_after");
        load(8'h3C);
        drv(1'b0, 1'b1, 3'd4, 4'd15, 1'b0, 1'b0, 8'h00); tick("sat_start");
        idle();
        for (int k = 0; k < 8; k++) tick("sat_step");
        chk("sat_const", {24'd0, o_q}, 32'h3C);
        tick("sat_after");

        // start+en together, then noisy controls during the burst
        load(8'h5A);
        drv(1'b1, 1'b1, 3'd1, 4'd4, 1'b1, 1'b0, 8'h00); tick("start_en");
        chk("start_en_const", {24'd0, o_q}, 32'h5A);
        for (int k = 0; k < 4; k++) begin
            drv(1'($urandom), 1'($urandom), 3'($urandom), 4'($urandom), 1'b1, 1'($urandom), 8'($urandom));
            tick("noisy");
        end
        idle(); tick("noisy_after");

        // Reset in the middle of a 5-step burst
        load(8'h5A);
        drv(1'b0, 1'b1, 3'd1, 4'd5, 1'b1, 1'b0, 8'h00); tick("rst_start");
        idle();
        tick("rst_step1");
        tick("rst_step2");
        #2;
        i_rst_n = 1'b0;
        #1;
        model_reset();
        check_all("midrst");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int k = 0; k < 6; k++) tick("post_rst");

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            drv(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), 3'($urandom),
                4'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
            tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
